// File: rtl/ahb_uart_tx.sv
// ---------------------------------------------------------------------------
// ahb_uart_tx -- AHB-Lite slave UART transmitter (8N1, LSB first)
//
// CPU writes to DATA are buffered in a small TX FIFO and shifted out on TXD.
// STATUS and BAUDDIV are readable/writable over the same bus.
//
// Register map (word offsets):
//   0x0 DATA    W   HWDATA[7:0] pushed to the FIFO (reads return 0)
//   0x4 STATUS  R   [0] full [1] empty [2] busy [3] overflow [12:8] level
//               W   writing 1 to bit 3 clears overflow
//   0x8 BAUDDIV RW  [15:0]; bit period = BAUDDIV+1 HCLK cycles
//   0xC         reads 0, writes ignored
//
// Configuration macro:
//   AHB_UART_TX_STALL_EN  when defined, a DATA write that finds the FIFO full
//                         holds HREADYOUT low until a slot frees instead of
//                         dropping the byte and setting overflow.
//
// Ports:
//   HCLK, HRESET          clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE,
//   HWDATA, HREADY        AHB-Lite slave inputs
//   HRDATA, HREADYOUT,
//   HRESP                 AHB-Lite slave outputs (HRESP always OKAY)
//   TXD                   serial output, idle high
//   TX_IRQ                high while FIFO empty and serializer idle
// ---------------------------------------------------------------------------
module ahb_uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] BAUDDIV_RST = 16'd433
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [11:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        TXD,
    output logic        TX_IRQ
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_BAUD   = 2'd2,
        REG_NONE   = 2'd3
    } reg_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Address phase capture
    // ------------------------------------------------------------------
    logic       aph_valid_q;
    logic       aph_write_q;
    reg_e       aph_addr_q;
    logic [2:0] aph_size_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            aph_valid_q <= 1'b0;
            aph_write_q <= 1'b0;
            aph_addr_q  <= REG_DATA;
            aph_size_q  <= 3'd0;
        end else if (HREADY) begin
            aph_valid_q <= HSEL & HTRANS[1];
            aph_write_q <= HWRITE;
            aph_addr_q  <= reg_e'(HADDR[3:2]);
            aph_size_q  <= HSIZE;
        end
    end

    // ------------------------------------------------------------------
    // FIFO and serializer state declarations
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             data_wr;
    logic             reg_wr;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [15:0] div_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        txd_q;
    logic        tx_irq_q;
    logic [15:0] bauddiv_q;
    logic        overflow_q;

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);

    // The serializer takes a byte either when idle or at the last cycle of a
    // stop bit, so consecutive frames run with no gap.
    assign pop = ~fifo_empty &
                 ((state_q == ST_IDLE) | ((state_q == ST_STOP) & (cnt_q == 16'd0)));

    // ------------------------------------------------------------------
    // Data phase: wait-state generation and write strobes
    // ------------------------------------------------------------------
`ifdef AHB_UART_TX_STALL_EN
    // A pop on this edge frees the slot, so the stalled write completes now.
    assign HREADYOUT = ~(aph_valid_q & aph_write_q & (aph_addr_q == REG_DATA) &
                         fifo_full & ~pop);
`else
    assign HREADYOUT = 1'b1;
`endif
    assign HRESP = 1'b0;

    assign reg_wr  = aph_valid_q & aph_write_q & HREADYOUT;
    assign data_wr = reg_wr & (aph_addr_q == REG_DATA);
    assign push    = data_wr & (~fifo_full | pop);
    assign ovf_set = data_wr & fifo_full & ~pop;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; the pointers and level alone
    // decide which entries are valid, so stale contents are never observed.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= HWDATA[7:0];
        end
    end

    // NOTE: the default assignment at the top keeps this block purely
    // combinational; a path that leaves level_d unassigned would infer a latch.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            bauddiv_q  <= BAUDDIV_RST;
            overflow_q <= 1'b0;
        end else begin
            if (reg_wr && aph_addr_q == REG_BAUD) begin
                bauddiv_q <= HWDATA[15:0];
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (reg_wr && aph_addr_q == REG_STATUS && HWDATA[3]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            div_q    <= BAUDDIV_RST;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            txd_q    <= 1'b1;
            tx_irq_q <= 1'b1;
        end else begin
            tx_irq_q <= fifo_empty & (state_q == ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        // Divisor is sampled per frame so a mid-frame
                        // BAUDDIV write only affects the next frame.
                        shift_q <= mem_q[rd_ptr_q];
                        div_q   <= bauddiv_q;
                        cnt_q   <= bauddiv_q;
                        txd_q   <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q   <= div_q;
                        bit_q   <= 3'd0;
                        txd_q   <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q   <= div_q;
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            txd_q <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == 16'd0) begin
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            div_q   <= bauddiv_q;
                            cnt_q   <= bauddiv_q;
                            txd_q   <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign TXD    = txd_q;
    assign TX_IRQ = tx_irq_q;

    // ------------------------------------------------------------------
    // Read data, driven from the registered address phase
    // ------------------------------------------------------------------
    logic [4:0] level_rd;
    assign level_rd = 5'(level_q);

    always_comb begin
        HRDATA = 32'd0;
        if (aph_valid_q && !aph_write_q) begin
            case (aph_addr_q)
                REG_STATUS: begin
                    HRDATA[0]    = fifo_full;
                    HRDATA[1]    = fifo_empty;
                    HRDATA[2]    = (state_q != ST_IDLE);
                    HRDATA[3]    = overflow_q;
                    HRDATA[12:8] = level_rd;
                end
                REG_BAUD: HRDATA[15:0] = bauddiv_q;
                default:  HRDATA = 32'd0;
            endcase
        end
    end

    // Bus fields this slave deliberately ignores.
    logic unused_bits;
    assign unused_bits = ^{HADDR[11:4], HADDR[1:0], HTRANS[0], HWDATA[31:16], aph_size_q};

endmodule

// File: tb/tb_ahb_uart_tx.sv
module tb_ahb_uart_tx;

    logic        HCLK   = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL   = 1'b0;
    logic [11:0] HADDR  = 12'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE  = 3'b000;
    logic [31:0] HWDATA = 32'h0;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        TXD;
    logic        TX_IRQ;

    // Single-slave bus: the interconnect returns this slave's ready.
    assign HREADY = HREADYOUT;

    ahb_uart_tx dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .TXD       (TXD),
        .TX_IRQ    (TX_IRQ)
    );

    always #5 HCLK = ~HCLK;

    int          checks = 0;
    int          errors = 0;
    int          stall_cycles = 0;
    int          cyc_cnt = 0;
    logic [7:0]  sb_q[$];
    int          start_cycles[$];
    logic [31:0] burst_data[$];
    bit          mon_en = 1'b0;
    int          mon_p = 4;
    logic        txd_prev = 1'b1;

    always @(posedge HCLK) cyc_cnt <= cyc_cnt + 1;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // TXD monitor: decodes frames and compares against the scoreboard
    // ------------------------------------------------------------------
    task automatic decode_frame();
        logic [7:0] got;
        logic [7:0] exp;
        logic       bitv;
        int         cyc = 0;
        int         p = mon_p;
        got = 8'h00;
        start_cycles.push_back(cyc_cnt);
        for (int j = 0; j < 10; j++) begin
            while (cyc < j * p + p / 2) begin
                @(negedge HCLK);
                cyc++;
            end
            bitv = TXD;
            if (j == 0) begin
                checks++;
                if (bitv !== 1'b0) begin
                    errors++;
                    $display("FAIL start_bit got %b expected 0", bitv);
                end
            end else if (j == 9) begin
                checks++;
                if (bitv !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_bit got %b expected 1", bitv);
                end
            end else begin
                got[j-1] = bitv;
            end
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected got %02h expected no frame", got);
        end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL frame_data got %02h expected %02h", got, exp);
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge HCLK);
            if (mon_en && txd_prev === 1'b1 && TXD === 1'b0) decode_frame();
            txd_prev = TXD;
        end
    end

    // ------------------------------------------------------------------
    // Bus tasks (all start and end 1 ns after a rising edge)
    // ------------------------------------------------------------------
    task automatic wait_ready_edge(input string what);
        int   n = 0;
        logic ok;
        do begin
            @(negedge HCLK);
            ok = HREADY;
            if (!ok) stall_cycles++;
            @(posedge HCLK);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout hready low for %0d cycles expected release", what, n);
        end
    endtask

    task automatic ahb_write(input logic [11:0] a, input logic [31:0] d, input logic [2:0] sz);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = sz;
        wait_ready_edge("wr_addr");
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = d;
        wait_ready_edge("wr_data");
    endtask

    task automatic ahb_read(input logic [11:0] a, output logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = 3'b010;
        wait_ready_edge("rd_addr");
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        d = HRDATA;
        @(posedge HCLK);
        #1;
    endtask

    // Pipelined writes of burst_data to one address.
    task automatic ahb_burst_write(input logic [11:0] a);
        int n = burst_data.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a; HSIZE = 3'b000;
            end else begin
                HSEL = 1'b0; HTRANS = 2'b00;
            end
            if (i > 0) HWDATA = burst_data[i-1];
            wait_ready_edge("burst");
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge HCLK);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending frames expected 0", sb_q.size());
        end
        repeat (8) @(negedge HCLK);
        @(posedge HCLK);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] rd;
        logic [11:0] addrs [4] = '{12'h004, 12'h008, 12'h000, 12'h00C};
        logic [31:0] exps  [4] = '{32'h0000_0002, 32'h0000_01B1, 32'h0, 32'h0};
        checks += 5;
        if (HRDATA !== 32'h0)   begin errors++; $display("FAIL rst_hrdata got %h expected 0", HRDATA); end
        if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got %b expected 1", HREADYOUT); end
        if (HRESP !== 1'b0)     begin errors++; $display("FAIL rst_hresp got %b expected 0", HRESP); end
        if (TXD !== 1'b1)       begin errors++; $display("FAIL rst_txd got %b expected 1", TXD); end
        if (TX_IRQ !== 1'b1)    begin errors++; $display("FAIL rst_irq got %b expected 1", TX_IRQ); end
        for (int i = 0; i < 4; i++) begin
            ahb_read(addrs[i], rd);
            checks++;
            if (rd !== exps[i]) begin
                errors++;
                $display("FAIL rst_read_%03h got %h expected %h", addrs[i], rd, exps[i]);
            end
        end
    endtask

    task automatic test_registers();
        logic [31:0] rd;
        ahb_write(12'h00C, 32'hFFFF_FFFF, 3'b010);
        ahb_write(12'h004, 32'hFFFF_FFF7, 3'b010);
        ahb_read(12'h004, rd);
        checks++;
        if (rd !== 32'h0000_0002) begin errors++; $display("FAIL reg_status_ro got %h expected 00000002", rd); end
        ahb_read(12'h008, rd);
        checks++;
        if (rd !== 32'h0000_01B1) begin errors++; $display("FAIL reg_baud_kept got %h expected 000001b1", rd); end
        checks++;
        if (TXD !== 1'b1) begin errors++; $display("FAIL reg_txd_idle got %b expected 1", TXD); end
        ahb_write(12'h008, 32'hABCD_0003, 3'b010);
        ahb_read(12'h008, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin errors++; $display("FAIL reg_baud_write got %h expected 00000003", rd); end
    endtask

    task automatic test_frame_timing();
        logic [9:0] frame = {1'b1, 8'h55, 1'b0};
        mon_p  = 4;
        mon_en = 1'b1;
        sb_q.push_back(8'h55);
        ahb_write(12'h000, 32'hFFFF_FF55, 3'b000);
        @(negedge HCLK);
        checks++;
        if (TXD !== 1'b1) begin errors++; $display("FAIL timing_pre_start got %b expected 1", TXD); end
        for (int k = 0; k < 40; k++) begin
            @(negedge HCLK);
            checks++;
            if (TXD !== frame[k/4]) begin
                errors++;
                $display("FAIL timing_txd_cycle%0d got %b expected %b", k, TXD, frame[k/4]);
            end
            if (k == 20) begin
                checks++;
                if (TX_IRQ !== 1'b0) begin errors++; $display("FAIL timing_irq_busy got %b expected 0", TX_IRQ); end
            end
        end
        @(negedge HCLK);
        checks++;
        if (TXD !== 1'b1) begin errors++; $display("FAIL timing_post_stop got %b expected 1", TXD); end
        @(negedge HCLK);
        checks++;
        if (TX_IRQ !== 1'b1) begin errors++; $display("FAIL timing_irq_done got %b expected 1", TX_IRQ); end
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int          nframes;
        start_cycles.delete();
        burst_data.delete();
        for (int i = 0; i < 6; i++) burst_data.push_back(32'h41 + i);
`ifdef AHB_UART_TX_STALL_EN
        for (int i = 0; i < 6; i++) sb_q.push_back(8'(8'h41 + i));
        nframes = 6;
`else
        for (int i = 0; i < 5; i++) sb_q.push_back(8'(8'h41 + i));
        nframes = 5;
`endif
        stall_cycles = 0;
        ahb_burst_write(12'h000);
        checks++;
`ifdef AHB_UART_TX_STALL_EN
        if (stall_cycles < 30 || stall_cycles > 40) begin
            errors++;
            $display("FAIL b2b_stall_cycles got %0d expected 30..40", stall_cycles);
        end
        ahb_read(12'h004, rd);
        checks++;
        if (rd !== 32'h0000_0405) begin errors++; $display("FAIL b2b_status got %h expected 00000405", rd); end
`else
        if (stall_cycles != 0) begin
            errors++;
            $display("FAIL b2b_stall_cycles got %0d expected 0", stall_cycles);
        end
        ahb_read(12'h004, rd);
        checks++;
        if (rd !== 32'h0000_040D) begin errors++; $display("FAIL b2b_status got %h expected 0000040d", rd); end
        // Writing 0 to bit 3 must leave overflow set.
        ahb_write(12'h004, 32'h0000_0000, 3'b010);
        ahb_read(12'h004, rd);
        checks++;
        if (rd !== 32'h0000_040D) begin errors++; $display("FAIL ovf_keep got %h expected 0000040d", rd); end
`endif
        // Clearing overflow leaves full, empty and level untouched.
        ahb_write(12'h004, 32'h0000_0008, 3'b010);
        ahb_read(12'h004, rd);
        checks++;
        if (rd !== 32'h0000_0405) begin errors++; $display("FAIL ovf_clear got %h expected 00000405", rd); end
        wait_drain(400);
        checks++;
        if (start_cycles.size() != nframes) begin
            errors++;
            $display("FAIL b2b_frame_count got %0d expected %0d", start_cycles.size(), nframes);
        end
        for (int i = 1; i < start_cycles.size(); i++) begin
            checks++;
            if (start_cycles[i] - start_cycles[i-1] != 40) begin
                errors++;
                $display("FAIL b2b_gap%0d got %0d expected 40", i, start_cycles[i] - start_cycles[i-1]);
            end
        end
        ahb_read(12'h004, rd);
        checks++;
        if (rd !== 32'h0000_0002) begin errors++; $display("FAIL b2b_status_end got %h expected 00000002", rd); end
        checks++;
        if (TX_IRQ !== 1'b1) begin errors++; $display("FAIL b2b_irq_end got %b expected 1", TX_IRQ); end
    endtask

    task automatic test_min_baud();
        ahb_write(12'h008, 32'h0000_0000, 3'b010);
        mon_p = 1;
        start_cycles.delete();
        burst_data.delete();
        burst_data.push_back(32'hC3);
        burst_data.push_back(32'h3C);
        sb_q.push_back(8'hC3);
        sb_q.push_back(8'h3C);
        ahb_burst_write(12'h000);
        wait_drain(100);
        checks++;
        if (start_cycles.size() != 2 || start_cycles[1] - start_cycles[0] != 10) begin
            errors++;
            $display("FAIL min_baud_frame frames %0d spacing %0d expected 2 frames spaced 10",
                     start_cycles.size(),
                     (start_cycles.size() == 2) ? start_cycles[1] - start_cycles[0] : -1);
        end
        ahb_write(12'h008, 32'h0000_0003, 3'b010);
        mon_p = 4;
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int          low_cycles = 0;
        mon_en = 1'b0;
        burst_data.delete();
        burst_data.push_back(32'h00);
        burst_data.push_back(32'h5A);
        ahb_burst_write(12'h000);
        repeat (12) @(negedge HCLK);
        checks += 2;
        if (TXD !== 1'b0)    begin errors++; $display("FAIL rstmid_txd_before got %b expected 0", TXD); end
        if (TX_IRQ !== 1'b0) begin errors++; $display("FAIL rstmid_irq_before got %b expected 0", TX_IRQ); end
        #2;
        HRESET = 1'b1;
        #1;
        checks += 2;
        if (TXD !== 1'b1)    begin errors++; $display("FAIL rstmid_txd got %b expected 1", TXD); end
        if (TX_IRQ !== 1'b1) begin errors++; $display("FAIL rstmid_irq got %b expected 1", TX_IRQ); end
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        for (int k = 0; k < 60; k++) begin
            @(negedge HCLK);
            if (TXD !== 1'b1) low_cycles++;
        end
        @(posedge HCLK);
        #1;
        checks++;
        if (low_cycles != 0) begin errors++; $display("FAIL rstmid_resume got %0d low cycles expected 0", low_cycles); end
        ahb_read(12'h004, rd);
        checks++;
        if (rd !== 32'h0000_0002) begin errors++; $display("FAIL rstmid_status got %h expected 00000002", rd); end
        ahb_read(12'h008, rd);
        checks++;
        if (rd !== 32'h0000_01B1) begin errors++; $display("FAIL rstmid_baud got %h expected 000001b1", rd); end
    endtask

    initial begin : main
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        test_reset();
        test_registers();
        test_frame_timing();
        test_back_to_back();
        test_min_baud();
        test_reset_mid_frame();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
